// File: rtl/tpu_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_layer_sequencer
//
// Command-level sequencer for one layer operation on tpu_datapath. A command
// is taken through a valid/ready handshake, then the block streams the
// layer's weight words into the datapath weight FIFO, launches the systolic
// array and waits for it, then launches the VPU stage and waits for it.
// The weight and accumulator double-buffer selects flip as steps complete,
// and a watchdog turns a hung datapath into a sticky error flag.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_ub_addr, cmd_rows,
//   cmd_wt_count, cmd_vpu_mode command fields, latched on acceptance
//   wt_in_valid / wt_in_ready weight-stream handshake, wt_in_data word
//   wt_fifo_wr, wt_fifo_data  registered weight-FIFO push
//   sys_start, sys_rows,
//   ub_rd_addr                systolic array launch and latched operands
//   sys_busy, sys_done        systolic array status
//   vpu_start, vpu_mode       VPU launch and latched mode
//   vpu_busy, vpu_done        VPU status
//   wt_buf_sel, acc_buf_sel   double-buffer selects
//   busy, done, err           sequencer status (done is a pulse, err sticky)
// ---------------------------------------------------------------------------
module tpu_layer_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_ub_addr,
   input  logic [7:0]  cmd_rows,
   input  logic [7:0]  cmd_wt_count,
   input  logic [3:0]  cmd_vpu_mode,
   input  logic        wt_in_valid,
   output logic        wt_in_ready,
   input  logic [15:0] wt_in_data,
   output logic        wt_fifo_wr,
   output logic [15:0] wt_fifo_data,
   output logic        sys_start,
   output logic [7:0]  sys_rows,
   output logic [7:0]  ub_rd_addr,
   input  logic        sys_busy,
   input  logic        sys_done,
   output logic        vpu_start,
   output logic [3:0]  vpu_mode,
   input  logic        vpu_busy,
   input  logic        vpu_done,
   output logic        wt_buf_sel,
   output logic        acc_buf_sel,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WT,
      START_SYS,
      WAIT_SYS,
      START_VPU,
      WAIT_VPU,
      DONE,
      ERROR
   } state_t;

   // The watchdog value seen in the last permitted waiting cycle; reaching
   // it with the done input still low means the limit is hit on this edge.
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [7:0]  wt_remaining;
   logic [15:0] wdog;
   logic        accept;
   logic        beat;
   logic        last_beat;

   assign accept    = cmd_valid && (state == IDLE);
   assign beat      = wt_in_valid && (state == LOAD_WT);
   assign last_beat = beat && (wt_remaining == 8'd1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake/pulse outputs. The start pulses are gated by
   // the busy inputs combinationally so a start is never issued into a
   // stage that is still working, and lasts exactly the launching cycle.
   // A done input in the same cycle the watchdog limit is hit takes
   // priority, so a late-but-in-time completion still succeeds.
   always_comb begin
      next_state  = state;
      cmd_ready   = 1'b0;
      wt_in_ready = 1'b0;
      sys_start   = 1'b0;
      vpu_start   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               if (cmd_rows == 8'd0) begin
                  next_state = DONE;
               end else if (cmd_wt_count == 8'd0) begin
                  next_state = START_SYS;
               end else begin
                  next_state = LOAD_WT;
               end
            end
         end
         LOAD_WT: begin
            wt_in_ready = 1'b1;
            if (last_beat) begin
               next_state = START_SYS;
            end
         end
         START_SYS: begin
            if (!sys_busy) begin
               sys_start  = 1'b1;
               next_state = WAIT_SYS;
            end
         end
         WAIT_SYS: begin
            if (sys_done) begin
               next_state = START_VPU;
            end else if (wdog >= WDOG_LAST) begin
               next_state = ERROR;
            end
         end
         START_VPU: begin
            if (!vpu_busy) begin
               vpu_start  = 1'b1;
               next_state = WAIT_VPU;
            end
         end
         WAIT_VPU: begin
            if (vpu_done) begin
               next_state = DONE;
            end else if (wdog >= WDOG_LAST) begin
               next_state = ERROR;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         ERROR: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Command latch, weight-count tracking and the registered FIFO push.
   // The FIFO push lags the accepted beat by one cycle, so the final push
   // coincides with the systolic start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_rows     <= 8'd0;
         ub_rd_addr   <= 8'd0;
         vpu_mode     <= 4'd0;
         wt_remaining <= 8'd0;
         wt_fifo_wr   <= 1'b0;
         wt_fifo_data <= 16'd0;
      end else begin
         wt_fifo_wr <= beat;
         if (accept) begin
            sys_rows     <= cmd_rows;
            ub_rd_addr   <= cmd_ub_addr;
            vpu_mode     <= cmd_vpu_mode;
            wt_remaining <= cmd_wt_count;
         end else if (beat) begin
            wt_remaining <= wt_remaining - 8'd1;
         end
         if (beat) begin
            wt_fifo_data <= wt_in_data;
         end
      end
   end

   // Buffer selects and the sticky error flag. The weight select flips as
   // the last beat is taken; the accumulator select flips on the way into
   // DONE from a real layer, so the no-op path and the error path leave it
   // alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wt_buf_sel  <= 1'b0;
         acc_buf_sel <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (last_beat) begin
            wt_buf_sel <= ~wt_buf_sel;
         end
         if ((state == WAIT_VPU) && vpu_done) begin
            acc_buf_sel <= ~acc_buf_sel;
         end
         if (accept) begin
            err <= 1'b0;
         end else if (next_state == ERROR) begin
            err <= 1'b1;
         end
      end
   end

   // Watchdog. The START states are the only way into the WAIT states, so
   // holding the counter at zero there clears it on entry to each wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= 16'd0;
      end else if ((state == START_SYS) || (state == START_VPU)) begin
         wdog <= 16'd0;
      end else if (((state == WAIT_SYS) && !sys_done) ||
                   ((state == WAIT_VPU) && !vpu_done)) begin
         wdog <= wdog + 16'd1;
      end
   end

endmodule

// File: doc/tpu_layer_sequencer.md
# tpu_layer_sequencer

Command-level sequencer that drives the control inputs of `tpu_datapath` for one layer operation. It accepts a command through a valid/ready handshake, then runs three steps in order:

- streams the layer's weight words into the datapath's weight FIFO;
- launches the systolic array and waits for it to finish;
- launches the activation/VPU stage and waits for it to finish.

It flips the weight and accumulator double-buffer selects as steps complete, and a watchdog converts a hung datapath into a sticky error. It sits between the host/command front-end and `tpu_datapath`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum number of cycles spent waiting for `sys_done` or `vpu_done` before the error path is taken.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command (IDLE only).
- `cmd_ub_addr`  in  8  unified-buffer start row.
- `cmd_rows`  in  8  activation rows to process.
- `cmd_wt_count`  in  8  weight words to stream; 0 reuses resident weights.
- `cmd_vpu_mode`  in  4  VPU mode for this layer.
- `wt_in_valid` / `wt_in_ready`  in/out  1  weight-stream handshake.
- `wt_in_data`  in  16  weight word (bits 9:8 carry the column tile ID).
- `wt_fifo_wr`  out  1  registered weight-FIFO push.
- `wt_fifo_data`  out  16  registered weight word.
- `sys_start`  out  1  one-cycle start pulse to the systolic array.
- `sys_rows`  out  8  latched `cmd_rows`.
- `ub_rd_addr`  out  8  latched `cmd_ub_addr`.
- `sys_busy`, `sys_done`  in  1  systolic array status.
- `vpu_start`  out  1  one-cycle start pulse to the VPU.
- `vpu_mode`  out  4  latched `cmd_vpu_mode`.
- `vpu_busy`, `vpu_done`  in  1  VPU status.
- `wt_buf_sel`, `acc_buf_sel`  out  1  double-buffer selects.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky timeout flag.

## Operation
States: IDLE, LOAD_WT, START_SYS, WAIT_SYS, START_VPU, WAIT_VPU, DONE, ERROR.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`: latch all `cmd_*` fields, clear `err`.
  - Next state:
    - `cmd_rows`==0: DONE (no-op command; no starts issued, no select toggles).
    - else `cmd_wt_count`==0: START_SYS.
    - else: LOAD_WT.
- **LOAD_WT**
  - `wt_in_ready`=1 (0 in every other state).
  - Each accepted beat sets `wt_fifo_wr`=1 and `wt_fifo_data`=`wt_in_data` on the next cycle, and decrements the remaining count.
  - On acceptance of the last beat: toggle `wt_buf_sel`, go to START_SYS.
  - Gaps in `wt_in_valid` are allowed; the block stalls with no timeout.
- **START_SYS**
  - If `sys_busy`=1, hold with `sys_start`=0.
  - Otherwise assert `sys_start`=1 for exactly this cycle and go to WAIT_SYS.
- **WAIT_SYS**
  - On `sys_done`=1: go to START_VPU.
  - `sys_done` is not sampled in the START_SYS cycle.
- **START_VPU / WAIT_VPU**
  - Same rules as START_SYS / WAIT_SYS, using `vpu_busy`, `vpu_start` and `vpu_done`.
- **DONE**
  - `done`=1 for one cycle.
  - Toggle `acc_buf_sel`, except for the rows==0 no-op.
  - Go to IDLE.
- **Watchdog**
  - 16-bit counter, cleared on entry to WAIT_SYS or WAIT_VPU, incremented each cycle spent in those states while the corresponding done input is low.
  - When the counter reaches `TIMEOUT_CYCLES` → ERROR.
  - A done input arriving in the same cycle the limit is reached wins: completion proceeds normally.
- **ERROR**
  - One cycle; set `err`=1 (sticky).
  - No `done` pulse, no `acc_buf_sel` toggle.
  - Go to IDLE.
- `sys_rows`, `ub_rd_addr` and `vpu_mode` hold the latched values from command acceptance until the next acceptance.

## Timing
- Reset (asynchronous, any state, including mid-command): state=IDLE and all outputs 0. This includes `wt_fifo_wr`, both start pulses, both buffer selects, `done`, `err` and `busy`. Any in-flight command is abandoned.
- Command accepted in cycle 0 → state LOAD_WT in cycle 1; `busy`=1 from cycle 1.
- Weight beat accepted in cycle t → `wt_fifo_wr`=1 in cycle t+1.
- Last beat accepted in cycle k → `sys_start` in cycle k+1. This is the same cycle as the final `wt_fifo_wr`. The `wt_buf_sel` toggle is also visible in k+1.
- `cmd_wt_count`=0 → `sys_start` in cycle 1.
- `sys_done` in cycle m → `vpu_start` in m+1 (if `vpu_busy`=0).
- `vpu_done` in cycle n → `done` and the `acc_buf_sel` toggle in n+1 → `cmd_ready` in n+2.
- rows==0 no-op: `done` in cycle 1, `cmd_ready` in cycle 2.
- Back-to-back throughput: one command per (work + 2) cycles minimum.

## Test plan
- **Basic layer:** command (addr=0x10, rows=3, wt_count=3, mode=2). Stream 3 beats at 0x0011, 0x0122, 0x0233 → 3 `wt_fifo_wr` pulses carrying those words, then one `sys_start` with `sys_rows`=3 and `ub_rd_addr`=0x10. Drive `sys_done` 5 cycles later → `vpu_start` with `vpu_mode`=2. Drive `vpu_done` → one `done` pulse; `wt_buf_sel`=1, `acc_buf_sel`=1.
- **Weight reuse and no-op:** wt_count=0, rows=2 → `sys_start` in cycle 1, no `wt_fifo_wr`, `wt_buf_sel` unchanged. Then rows=0 → `done` in cycle 1, no starts, `acc_buf_sel` unchanged.
- **Stall/backpressure:** `wt_in_valid` toggled 1,0,0,1 → exactly 2 writes; hold `sys_busy`=1 for 4 cycles in START_SYS → `sys_start` delayed until `sys_busy` falls, and is exactly 1 cycle long.
- **Timeout:** TIMEOUT_CYCLES=8, never assert `sys_done` → ERROR after 8 WAIT_SYS cycles, `err`=1, no `done`, `cmd_ready`=1 next cycle. Next accepted command clears `err`. Separately, `sys_done` asserted on cycle 8 → normal completion.
- **Reset mid-operation:** assert `rst` during LOAD_WT after 1 of 3 beats → all outputs 0 immediately. A new command then completes normally with `wt_buf_sel` starting from 0.
